// File: rtl/shift_seq_pkg.sv
// Shared encodings for the LED-bank shift sequencer: run modes, FSM states and
// shifter constants.
package shift_seq_pkg;

  localparam logic [1:0] MODE_ONCE_L   = 2'd0;
  localparam logic [1:0] MODE_WRAP_L   = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;
  localparam logic [1:0] MODE_ONCE_PP  = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic       DIR_LEFT  = 1'b0;
  localparam logic       DIR_RIGHT = 1'b1;

  localparam logic [2:0] POS_MAX      = 3'd7;
  localparam logic [7:0] LOAD_PATTERN = 8'b0000_0001;

endpackage

// File: rtl/tick_div.sv
// Step-rate prescaler: counts 0..period_i and emits tick_o on the terminal count;
// held at zero while clr_i is high.
module tick_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] period_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] count_q, count_d;

  assign tick_o  = (count_q == period_i);
  assign count_d = (clr_i || tick_o) ? '0 : count_q + DIV_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer for the 8-bit one-hot LED shifter: issues load/step_en/lr pulses for
// four run modes at a programmable step rate and tracks the lit bit position.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  output logic             load,
  output logic             step_en,
  output logic             lr,
  output logic [2:0]       pos,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             load_q, load_d, step_q, step_d, lr_q, lr_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             dir_q, dir_d, last_q, last_d;
  logic [2:0]       pos_q, pos_d;
  logic             idle, tick, nxt_dir;

  assign idle = (state_q == ST_IDLE);

  tick_div #(.DIV_W(DIV_W)) u_tick_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_i    (idle),
    .period_i (div_q),
    .tick_o   (tick)
  );

  // pos_d already includes the pulse on the outputs this cycle, so tick decisions
  // see the shifter position the next step will start from.
  assign pos_d   = load_q ? 3'd0 :
                   step_q ? (lr_q ? pos_q - 3'd1 : pos_q + 3'd1) : pos_q;
  assign nxt_dir = (pos_d == 3'd0) ? DIR_LEFT : (pos_d == POS_MAX) ? DIR_RIGHT : dir_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    div_d   = div_q;
    load_d  = 1'b0;
    step_d  = 1'b0;
    lr_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dir_d   = dir_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_LOAD;
          mode_d  = mode;
          div_d   = div;
          load_d  = 1'b1;
          busy_d  = 1'b1;
          dir_d   = DIR_LEFT;
          last_d  = 1'b0;
        end
      end
      ST_LOAD, ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          last_d  = 1'b0;
        end else if (last_q) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          last_d  = 1'b0;
        end else begin
          state_d = ST_RUN;
          if (tick) begin
            case (mode_q)
              MODE_ONCE_L: begin
                step_d = 1'b1;
                last_d = (pos_d == POS_MAX - 3'd1);
              end
              MODE_WRAP_L: begin
                if (pos_d == POS_MAX) load_d = 1'b1;
                else                  step_d = 1'b1;
              end
              default: begin
                step_d = 1'b1;
                lr_d   = nxt_dir;
                dir_d  = nxt_dir;
                last_d = (mode_q == MODE_ONCE_PP) && (nxt_dir == DIR_RIGHT) && (pos_d == 3'd1);
              end
            endcase
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ONCE_L;
      div_q   <= '0;
      load_q  <= 1'b0;
      step_q  <= 1'b0;
      lr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= DIR_LEFT;
      last_q  <= 1'b0;
      pos_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      div_q   <= div_d;
      load_q  <= load_d;
      step_q  <= step_d;
      lr_q    <= lr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
      last_q  <= last_d;
      pos_q   <= pos_d;
    end
  end

  assign load    = load_q;
  assign step_en = step_q;
  assign lr      = lr_q;
  assign pos     = pos_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
